// File: rtl/gear_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gear_pkg
//  Description : Shared definitions for the GeAr error-correcting adder:
//                FSM state encoding, geometry helpers (L, K, window-low
//                index) and a parameter legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package gear_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } gear_state_t;

    // Bits produced by sub-adder 0 (prediction + result bits).
    function automatic int gear_l(input int p, input int r);
        return p + r;
    endfunction

    // Number of sub-adders beyond the first.
    function automatic int gear_k(input int size, input int p, input int r);
        return (size - p - r) / r;
    endfunction

    // Lowest (1-based) bit of sub-adder i's prediction window.
    function automatic int gear_win_lo(input int i, input int r);
        return i * r + 1;
    endfunction

    // Geometry must tile SIZE exactly with at least one extra sub-adder,
    // and the correction budget cannot exceed the number of sub-adders.
    function automatic bit gear_params_ok(input int size, input int p,
                                          input int r, input int max_corr);
        return (p >= 1) && (r >= 1) && (size > p + r) &&
               (((size - p - r) % r) == 0) &&
               (max_corr >= 0) && (max_corr <= gear_k(size, p, r));
    endfunction

endpackage
`default_nettype wire

// File: rtl/gear_core.sv
`default_nettype none
// ============================================================================
//  Module      : gear_core
//  Description : Combinational GeAr evaluation. Produces the approximate sum,
//                carry-out and per-sub-adder carry-prediction error flags for
//                an operand pair, carry-in and forced-carry (fix) vector.
//  Ports       : a, b   - operands (bit j of the description is index j-1)
//                cin    - carry-in into sub-adder 0
//                fix    - forced window carry-in per sub-adder 1..K
//                sum    - approximate sum
//                cout   - carry-out from the last sub-adder's chain
//                err    - prediction error flag per sub-adder 1..K
//  Revision    : 1.0 - initial release
// ============================================================================
module gear_core
    import gear_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int P    = 4,
    parameter int R    = 2
) (
    input  logic [SIZE-1:0]             a,
    input  logic [SIZE-1:0]             b,
    input  logic                        cin,
    input  logic [gear_k(SIZE, P, R):1] fix,
    output logic [SIZE-1:0]             sum,
    output logic                        cout,
    output logic [gear_k(SIZE, P, R):1] err
);

    localparam int c_l = gear_l(P, R);
    localparam int c_k = gear_k(SIZE, P, R);

    logic [SIZE-1:0] w_g;
    logic [SIZE-1:0] w_p;
    // w_gen[j]: carry out of bit j as seen by the sub-adder owning bit j.
    logic [SIZE:0]   w_gen;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin : p_eval
        logic c;
        logic all_p;
        c     = cin;
        all_p = 1'b1;
        sum   = '0;
        err   = '0;
        w_gen = '0;
        w_gen[0] = cin;

        // Sub-adder 0 is an exact ripple over bits 1..L.
        for (int j = 1; j <= c_l; j++) begin
            sum[j-1] = w_p[j-1] ^ c;
            c        = w_g[j-1] | (w_p[j-1] & c);
            w_gen[j] = c;
        end

        // Each later sub-adder restarts from its fix bit, runs the
        // prediction window (carries only) and then owns R result bits.
        for (int i = 1; i <= c_k; i++) begin
            c = fix[i];
            for (int j = gear_win_lo(i, R); j <= i * R + P; j++) begin
                c = w_g[j-1] | (w_p[j-1] & c);
            end
            for (int j = i * R + P + 1; j <= i * R + P + R; j++) begin
                sum[j-1] = w_p[j-1] ^ c;
                c        = w_g[j-1] | (w_p[j-1] & c);
                w_gen[j] = c;
            end
        end

        // A window mispredicts when a real carry arrives at its low edge and
        // the whole window propagates it; already-forced windows are exempt.
        for (int i = 1; i <= c_k; i++) begin
            all_p = 1'b1;
            for (int j = gear_win_lo(i, R); j <= i * R + P; j++) begin
                all_p = all_p & w_p[j-1];
            end
            err[i] = w_gen[i*R] & all_p & ~fix[i];
        end
    end

    assign cout = w_gen[SIZE];

endmodule
`default_nettype wire

// File: rtl/gear_ec_adder.sv
`default_nettype none
// ============================================================================
//  Module      : gear_ec_adder
//  Description : Sequential GeAr approximate adder with error detection and
//                iterative correction. Flagged sub-adder carry-ins are forced
//                to 1 over successive EVAL cycles until the sum is exact or
//                MAX_CORR corrections have been spent.
//  Macro       : GEAR_CORRECT_EN - when defined, iterative correction is
//                built; otherwise EVAL always finishes in one cycle.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                in_valid/in_ready        - operand handshake
//                a, b, cin                - operands and carry-in
//                out_valid/out_ready      - result handshake
//                sum, cout                - delivered result
//                approx_err               - error on first evaluation
//                exact                    - no residual error in result
//                corr_count               - correction cycles used
//  Revision    : 1.0 - initial release
// ============================================================================
module gear_ec_adder
    import gear_pkg::*;
#(
    parameter int SIZE     = 16,
    parameter int P        = 4,
    parameter int R        = 2,
    parameter int MAX_CORR = 5
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [SIZE-1:0]                      a,
    input  logic [SIZE-1:0]                      b,
    input  logic                                 cin,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [SIZE-1:0]                      sum,
    output logic                                 cout,
    output logic                                 approx_err,
    output logic                                 exact,
    output logic [$clog2(gear_k(SIZE, P, R)+1)-1:0] corr_count
);

    localparam int c_k  = gear_k(SIZE, P, R);
    localparam int c_cw = $clog2(c_k + 1);

    generate
        if (!gear_params_ok(SIZE, P, R, MAX_CORR)) begin : g_param_check
            $error("gear_ec_adder: illegal SIZE/P/R/MAX_CORR combination");
        end
    endgenerate

    gear_state_t     r_state;
    gear_state_t     w_state_nxt;
    logic [SIZE-1:0] r_a;
    logic [SIZE-1:0] r_b;
    logic            r_cin;
    logic [SIZE-1:0] r_sum;
    logic            r_cout;
    logic            r_approx;
    logic            r_exact;
    logic [c_k:1]    w_fix;
    logic [c_k:1]    w_err;
    logic [SIZE-1:0] w_sum;
    logic            w_cout;
    logic            w_load;
    logic            w_correct;
    logic            w_finish;
    logic            w_first;

`ifdef GEAR_CORRECT_EN
    logic [c_k:1]    r_fix;
    logic [c_cw-1:0] r_cnt;

    assign w_fix      = r_fix;
    assign w_first    = (r_cnt == '0);
    assign corr_count = r_cnt;
`else
    assign w_fix      = '0;
    assign w_first    = 1'b1;
    assign corr_count = '0;
`endif

    gear_core #(
        .SIZE (SIZE),
        .P    (P),
        .R    (R)
    ) u_core (
        .a    (r_a),
        .b    (r_b),
        .cin  (r_cin),
        .fix  (w_fix),
        .sum  (w_sum),
        .cout (w_cout),
        .err  (w_err)
    );

    assign in_ready   = (r_state == IDLE) && !rst;
    assign out_valid  = (r_state == DONE);
    assign sum        = r_sum;
    assign cout       = r_cout;
    assign approx_err = r_approx;
    assign exact      = r_exact;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_correct   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    w_load      = 1'b1;
                    w_state_nxt = EVAL;
                end
            end
            EVAL: begin
`ifdef GEAR_CORRECT_EN
                if ((|w_err) && (int'(r_cnt) < MAX_CORR)) begin
                    w_correct = 1'b1;
                end else begin
                    w_finish    = 1'b1;
                    w_state_nxt = DONE;
                end
`else
                w_finish    = 1'b1;
                w_state_nxt = DONE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_approx <= 1'b0;
            r_exact  <= 1'b0;
`ifdef GEAR_CORRECT_EN
            r_fix    <= '0;
            r_cnt    <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_a   <= a;
                r_b   <= b;
                r_cin <= cin;
`ifdef GEAR_CORRECT_EN
                r_fix <= '0;
                r_cnt <= '0;
`endif
            end
`ifdef GEAR_CORRECT_EN
            // All windows flagged this cycle are forced together; fix bits
            // are sticky so the chain converges within K corrections.
            if (w_correct) begin
                r_fix <= r_fix | w_err;
                r_cnt <= r_cnt + c_cw'(1);
            end
`endif
            if ((r_state == EVAL) && w_first) begin
                r_approx <= |w_err;
            end
            if (w_finish) begin
                r_sum   <= w_sum;
                r_cout  <= w_cout;
                r_exact <= ~(|w_err);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/gear_ec_adder.md
# gear_ec_adder

Sequential, parametrised GeAr approximate adder with built-in error detection and iterative correction. Operands enter through a valid/ready handshake. Each sub-adder's carry-prediction error is detected from the current partial result, and flagged carry-ins are forced to 1 over successive cycles until the sum is exact or a correction budget is spent. Used where most additions may finish in approximate latency but exact results must be recoverable on demand.

## Interface
- SIZE, 16, operand width in bits; (SIZE−P−R) must be divisible by R
- P, 4, carry-prediction bits per sub-adder
- R, 2, result bits per sub-adder beyond the first
- MAX_CORR, 5, maximum correction cycles per operation (0..K)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a, b  in  SIZE  operands, bits indexed 1..SIZE
- cin  in  1  carry-in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  SIZE  result
- cout  out  1  carry-out
- approx_err  out  1  error detected on the first (uncorrected) evaluation
- exact  out  1  no residual error detected in the delivered result
- corr_count  out  $clog2(K+1)  correction cycles used

## Operation
- Derived constants: L = P+R; K = (SIZE−L)/R; K ≥ 1 required.
- Sub-adder 0 covers bits 1..L and is exact from cin.
- Sub-adder i (1..K):
  - prediction window is bits iR+1..iR+P; output bits are iR+P+1..iR+P+R.
  - Window carry-in is fix[i] (0 or 1).
  - Generate chain: gen[j] = g[j] | p[j]&gen[j−1], with g = a&b and p = a^b.
- cout = gen[SIZE] from the last sub-adder's chain. sum[j] = p[j] ^ gen[j−1], taking each bit's gen from its owning sub-adder.
- Error flag: err[i] = gen[iR] & (AND of p[iR+1..iR+P]) & ~fix[i], where gen[iR] is taken from the current, partially fixed chain.
- FSM:
  - IDLE: in_ready=1. On handshake, register a, b, cin; clear fix and corr_count → EVAL.
  - EVAL: evaluate with the current fix vector.
    - If any err and corr_count < MAX_CORR: fix |= err, corr_count+1, stay in EVAL.
    - Otherwise latch sum, cout, and exact = ~|err → DONE.
    - approx_err is latched on the first EVAL cycle.
  - DONE: out_valid=1 and outputs held stable. On out_ready → IDLE.
- fix bits only set, never clear, so the sum converges within K corrections.
- All errors flagged in the same cycle are fixed together.

## Timing
- Reset values: state IDLE; in_ready=0 while rst=1; out_valid=0, sum=0, cout=0, approx_err=0, exact=0, corr_count=0; fix cleared.
- Latency from accept to out_valid: 2+n cycles, where n is the number of corrections (0..MAX_CORR).
- Throughput: at most one operation per 3+n cycles. in_ready is asserted only in IDLE.
- out_valid stays high with outputs stable until out_ready is sampled high.
- rst during EVAL or DONE aborts the operation; the next cycle shows reset values.
- MAX_CORR=0: the result is approximate, and exact reports whether any error was present.

## Configuration
- GEAR_CORRECT_EN defined: correction as described above.
- GEAR_CORRECT_EN undefined:
  - EVAL always proceeds to DONE; no fix/corr_count logic.
  - corr_count is tied to 0; exact = ~approx_err.
  - Latency is fixed at 2.

## Structure
- Shared package gear_pkg holds:
  - state enum (IDLE, EVAL, DONE);
  - functions for L, K and window-low index;
  - parameter legality check.
- Sub-module gear_core: combinational evaluation of sum, cout and err[1..K] for a given operand pair, cin and fix vector. The top level holds the FSM and registers.

## Test plan
Defaults used unless stated: SIZE=16, P=4, R=2, so K=5.
- No error: a=0x1234, b=0x0101 → sum=0x1335, cout=0, approx_err=0, exact=1, corr_count=0, out_valid 2 cycles after accept.
- Single correction: a=0x003E, b=0x0002 → approx 0x0000 detected; final sum=0x0040, exact=1, corr_count=1, latency 3.
- Chained correction: a=0xFFFE, b=0x0002 → cycle 1 fixes sub-adders 1–3, cycle 2 fixes 4–5; sum=0x0000, cout=1, corr_count=2, exact=1.
- Budget exhausted: same operands with MAX_CORR=1 → sum=0xF000, cout=0, approx_err=1, exact=0, corr_count=1.
- Back-pressure and reset:
  - hold out_ready=0 for 5 cycles → outputs stable and in_ready=0 throughout;
  - assert rst in EVAL → next cycle out_valid=0, in_ready=0, and a new operation after release completes correctly.
- Macro off: a=0x003E, b=0x0002 → sum=0x0000, approx_err=1, exact=0, corr_count=0, latency 2.
